interrupt_controller: RTL
=========================

Name: interrupt_controller

Overview:
- Sits between the interrupt sources (timer, I/O manager) and the single-cycle CPU, replacing the plain OR-and-register of interrupt lines.
- Detects rising edges on 8 request lines, latches them as pending and applies a CPU-writable mask.
- Selects the highest-priority enabled request and presents it to the CPU as request, id and handler vector.
- Runs a req/ack/eoi handshake; no nesting.

Parameters:
- NUM_IRQ, 8, number of request lines; fixed at 8 for this revision.
- VECTOR_BASE, 16'h0010, handler address for irq 0.
- VECTOR_STRIDE, 16'h0004, address distance between consecutive handlers.
- MASK_RESET, 8'hFF, mask value after reset (1 = enabled).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- irq_in  in  8  request lines from timer/io, synchronous to clk
- mask_we  in  1  write strobe for the mask register
- mask_data  in  8  new mask value
- int_ack  in  1  CPU accepts the current request (1-cycle pulse)
- int_eoi  in  1  CPU finished the handler (return from interrupt, 1-cycle pulse)
- int_req  out  1  interrupt request to CPU
- int_id  out  3  id of the requested/serviced interrupt
- int_vector  out  16  handler address for int_id
- pending  out  8  pending register (status readback)
- mask  out  8  mask register (status readback)
- busy  out  1  high while in SERVICE

Behaviour:
- Reset (async, active-high) values:
  - state IDLE; pending 0; mask MASK_RESET; int_req 0; int_id 0; busy 0.
  - int_vector VECTOR_BASE; irq_q (previous-sample register) 0.
  - A line held high across reset release therefore registers exactly one edge.
- Edge detect: edge = irq_in & ~irq_q; irq_q <= irq_in every clk. Level-held lines produce a single edge.
- Pending:
  - pending[i] set on edge[i].
  - pending[i] cleared on the int_ack cycle for i == int_id.
  - Set and clear in the same cycle on the same bit: set wins (edge not lost).
- Mask: written on mask_we at the clock edge. Masked pending bits stay pending and become eligible once unmasked.
- Selection: eligible = pending & mask; lowest index wins (irq 0 = highest priority).
- State machine:
  - IDLE: if eligible != 0 -> REQUEST. Latch int_id = winner and int_vector = VECTOR_BASE + int_id*VECTOR_STRIDE (16-bit modulo). int_req is registered high.
  - REQUEST: int_req = 1; int_id and int_vector held stable, even if higher-priority edges arrive or the mask changes (the request is committed). int_ack -> SERVICE: int_req 0, busy 1, clear pending[int_id].
  - SERVICE: new edges still latch into pending; no new request. int_eoi -> IDLE, busy 0.
  - int_ack outside REQUEST and int_eoi outside SERVICE are ignored.
- Latency: irq_in rises before edge k -> pending set at edge k -> int_req high after edge k+1 (2 cycles). Back-to-back: eoi at edge m with another bit eligible -> IDLE after m -> int_req high after m+1.
- int_id and int_vector keep their last value in IDLE.

Decomposition:
- Shared include (cpu_defs.vh): state encodings IDLE=2'd0, REQUEST=2'd1, SERVICE=2'd2; NUM_IRQ; default VECTOR_BASE and VECTOR_STRIDE.
- One sub-module: priority_encoder8 — combinational, 8-bit in -> 3-bit index + valid, lowest index wins.

Test Plan:
- Reset with irq_in=0, then pulse irq_in[3] one cycle -> pending=8'h08; int_req high 2 cycles later; int_id=3; int_vector=16'h001C. int_ack -> pending=0, busy=1. int_eoi -> IDLE, int_req stays 0.
- Edges on bits 5 and 1 in the same cycle -> first int_id=1 (vector 16'h0014). After ack+eoi, int_id=5 (vector 16'h0024) one cycle after return to IDLE.
- mask_data=8'hFE written, edge on bit 0 -> pending=8'h01, no int_req. Write mask 8'hFF -> int_req 1 cycle later with int_id=0.
- In REQUEST with int_id=4, edge on bit 0 arrives -> int_id stays 4 until ack; bit 0 is requested after eoi.
- Edge on bit 2 in the same cycle as int_ack for int_id=2 -> pending[2] remains 1; re-requested after eoi.
- Assert reset mid-SERVICE with pending=8'h30 -> outputs immediately return to reset values. irq_in[6] held high through reset release -> exactly one request for id 6, no repeats while held.

Source files
------------

// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, sizing and vector defaults.
package interrupt_controller_pkg;

  localparam int          NUM_IRQ        = 8;
  localparam int          ID_W           = $clog2(NUM_IRQ);
  localparam logic [15:0] VECTOR_BASE_D  = 16'h0010;
  localparam logic [15:0] VECTOR_STRIDE_D = 16'h0004;
  localparam logic [7:0]  MASK_RESET_D   = 8'hFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Handler address wraps modulo 2^16 by construction of the 16-bit result.
  function automatic logic [15:0] irq_vector(input logic [15:0] base,
                                             input logic [15:0] stride,
                                             input logic [ID_W-1:0] id);
    return base + stride * {{(16-ID_W){1'b0}}, id};
  endfunction

endpackage

// File: rtl/priority_encoder8.sv
// Combinational 8-to-3 priority encoder; lowest set index wins.
module priority_encoder8
  import interrupt_controller_pkg::*;
(
  input  logic [NUM_IRQ-1:0] i_vec,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_valid
);

  always_comb begin
    o_idx   = '0;
    o_valid = |i_vec;
    // Scan downwards so the lowest set bit is the last, and therefore final, assignment.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Edge-triggered, maskable, fixed-priority interrupt controller with a
// req/ack/eoi handshake toward a single-cycle CPU; no nesting.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter logic [15:0] VECTOR_BASE   = VECTOR_BASE_D,
  parameter logic [15:0] VECTOR_STRIDE = VECTOR_STRIDE_D,
  parameter logic [7:0]  MASK_RESET    = MASK_RESET_D
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_data,
  input  logic               int_ack,
  input  logic               int_eoi,
  output logic               int_req,
  output logic [ID_W-1:0]    int_id,
  output logic [15:0]        int_vector,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask,
  output logic               busy
);

  state_t               r_state, w_state_next;
  logic [NUM_IRQ-1:0]   r_irq_q, r_pending, r_mask;
  logic                 r_int_req, r_busy;
  logic [ID_W-1:0]      r_int_id;
  logic [15:0]          r_int_vector;

  logic [NUM_IRQ-1:0]   w_edge, w_clear, w_pending_next, w_eligible;
  logic [ID_W-1:0]      w_winner, w_id_next;
  logic                 w_winner_valid, w_req_next, w_busy_next;
  logic [15:0]          w_vector_next;

  assign w_edge     = irq_in & ~r_irq_q;
  assign w_eligible = r_pending & r_mask;

  priority_encoder8 u_prio (
    .i_vec   (w_eligible),
    .o_idx   (w_winner),
    .o_valid (w_winner_valid)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    w_state_next  = r_state;
    w_req_next    = r_int_req;
    w_busy_next   = r_busy;
    w_id_next     = r_int_id;
    w_vector_next = r_int_vector;
    w_clear       = '0;

    unique case (r_state)
      IDLE: begin
        if (w_winner_valid) begin
          w_state_next  = REQUEST;
          w_req_next    = 1'b1;
          w_id_next     = w_winner;
          w_vector_next = irq_vector(VECTOR_BASE, VECTOR_STRIDE, w_winner);
        end
      end
      REQUEST: begin
        if (int_ack) begin
          w_state_next       = SERVICE;
          w_req_next         = 1'b0;
          w_busy_next        = 1'b1;
          w_clear[r_int_id]  = 1'b1;
        end
      end
      SERVICE: begin
        if (int_eoi) begin
          w_state_next = IDLE;
          w_busy_next  = 1'b0;
        end
      end
      default: w_state_next = IDLE;
    endcase

    // Applying the edge after the clear lets a same-cycle edge survive the ack.
    w_pending_next = (r_pending & ~w_clear) | w_edge;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_irq_q      <= '0;
      r_pending    <= '0;
      r_mask       <= MASK_RESET;
      r_int_req    <= 1'b0;
      r_busy       <= 1'b0;
      r_int_id     <= '0;
      r_int_vector <= VECTOR_BASE;
    end else begin
      r_state      <= w_state_next;
      r_irq_q      <= irq_in;
      r_pending    <= w_pending_next;
      r_int_req    <= w_req_next;
      r_busy       <= w_busy_next;
      r_int_id     <= w_id_next;
      r_int_vector <= w_vector_next;
      if (mask_we) r_mask <= mask_data;
    end
  end

  assign int_req    = r_int_req;
  assign int_id     = r_int_id;
  assign int_vector = r_int_vector;
  assign pending    = r_pending;
  assign mask       = r_mask;
  assign busy       = r_busy;

endmodule
